// File: rtl/wb_pkg.sv
// Shared writeback definitions: WB mux select encoding and long-latency FIFO depth.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_NPC = 2'b00,
    WB_ALU = 2'b01,
    WB_MEM = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/wb_sel_mux.sv
// 4:1 pipeline writeback data select driven by the control unit's WBmuxSel.
module wb_sel_mux
  import wb_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [1:0]   sel_i,
  input  logic [N-1:0] npc_i,
  input  logic [N-1:0] alu_i,
  input  logic [N-1:0] mem_i,
  input  logic [N-1:0] imm_i,
  output logic [N-1:0] data_o
);

  always_comb begin
    data_o = '0;
    unique case (wb_sel_e'(sel_i))
      WB_NPC:  data_o = npc_i;
      WB_ALU:  data_o = alu_i;
      WB_MEM:  data_o = mem_i;
      WB_IMM:  data_o = imm_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry long-latency result FIFO.
// Define WB_AGE_EN to compile starvation aging that stalls the pipeline for an old FIFO head.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned AGE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pipe_valid,
  input  logic [4:0]   pipe_rd,
  input  logic [1:0]   WBmuxSel,
  input  logic [N-1:0] ALUres,
  input  logic [N-1:0] MEMread,
  input  logic [N-1:0] NPCin,
  input  logic [N-1:0] IMMin,
  input  logic         mul_valid,
  output logic         mul_ready,
  input  logic [4:0]   mul_rd,
  input  logic [N-1:0] mul_data,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [N-1:0] rf_wdata,
  output logic         pipe_stall
);

  logic [N-1:0] pipe_data;

  wb_sel_mux #(
    .N (N)
  ) u_sel_mux (
    .sel_i  (WBmuxSel),
    .npc_i  (NPCin),
    .alu_i  (ALUres),
    .mem_i  (MEMread),
    .imm_i  (IMMin),
    .data_o (pipe_data)
  );

  logic [4:0]   fifo_rd_q   [FifoDepth];
  logic [N-1:0] fifo_data_q [FifoDepth];
  logic         wptr_q, rptr_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         fifo_nempty, push, pop, override;
  logic         win;
  logic [4:0]   win_rd;
  logic [N-1:0] win_data;

  assign fifo_nempty = (cnt_q != 2'd0);
  // Full check uses registered count only, so a same-cycle pop never frees a slot.
  assign mul_ready   = (cnt_q != 2'(FifoDepth));
  assign push        = mul_valid && mul_ready;

`ifdef WB_AGE_EN
  localparam int unsigned AgeW = $clog2(AGE_MAX + 1);

  logic [AgeW-1:0] age_q, age_d;

  assign override = fifo_nempty && (age_q == AgeW'(AGE_MAX));

  always_comb begin
    age_d = age_q;
    if (!fifo_nempty || pop) begin
      age_d = '0;
    end else if (age_q != AgeW'(AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      age_q <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  logic unused_age_max;
  assign unused_age_max = ^AGE_MAX;
  assign override       = 1'b0;
`endif

  assign pipe_stall = override && pipe_valid;

  always_comb begin
    win      = 1'b0;
    pop      = 1'b0;
    win_rd   = pipe_rd;
    win_data = pipe_data;
    if (override || (!pipe_valid && fifo_nempty)) begin
      pop      = 1'b1;
      win      = 1'b1;
      win_rd   = fifo_rd_q[rptr_q];
      win_data = fifo_data_q[rptr_q];
    end else if (pipe_valid) begin
      win = 1'b1;
    end
  end

  assign cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wptr_q]   <= mul_rd;
      fifo_data_q[wptr_q] <= mul_data;
    end
  end

  // An x0 winner still consumes its slot; only the write enable is suppressed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= win && (win_rd != 5'd0);
      if (win) begin
        rf_waddr <= win_rd;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected register-file writes in order.
module tb_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [1:0]  WBmuxSel;
  logic [31:0] ALUres, MEMread, NPCin, IMMin;
  logic        mul_valid, mul_ready;
  logic [4:0]  mul_rd;
  logic [31:0] mul_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];

  wb_arbiter #(
    .N       (32),
    .AGE_MAX (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .WBmuxSel   (WBmuxSel),
    .ALUres     (ALUres),
    .MEMread    (MEMread),
    .NPCin      (NPCin),
    .IMMin      (IMMin),
    .mul_valid  (mul_valid),
    .mul_ready  (mul_ready),
    .mul_rd     (mul_rd),
    .mul_data   (mul_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pipe_stall (pipe_stall)
  );

  always #5 clk = ~clk;

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
          errors++;
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks += 5;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b required 0", rf_we); end
    if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d required 0", rf_waddr); end
    if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h required 0", rf_wdata); end
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", mul_ready); end
    if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", pipe_stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_pipe();
    logic [1:0]  sels [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [31:0] vals [4] = '{32'h0000_0011, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0000_0005};
    NPCin = 32'h1000_0004; ALUres = 32'h11; MEMread = 32'hDEAD_BEEF; IMMin = 32'h5;
    for (int i = 0; i < 4; i++) begin
      pipe_valid = 1'b1;
      pipe_rd    = 5'(5 + i);
      WBmuxSel   = sels[i];
      exp_q.push_back('{rd: 5'(5 + i), data: vals[i]});
      cyc();
      checks++;
      if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we%0d: got %b required 1", i, rf_we); end
    end
    pipe_valid = 1'b0;
    cyc();
    checks += 3;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b required 0", rf_we); end
    if (rf_waddr !== 5'd8) begin errors++; $display("FAIL idle_waddr_hold: got %0d required 8", rf_waddr); end
    if (rf_wdata !== 32'h5) begin errors++; $display("FAIL idle_wdata_hold: got %h required 5", rf_wdata); end
    drain("pipe");
  endtask

  task automatic test_mul_idle();
    mul_valid = 1'b1; mul_rd = 5'd7; mul_data = 32'hABCD;
    exp_q.push_back('{rd: 5'd7, data: 32'hABCD});
    cyc();
    mul_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL mul_bypass: got we=%b at t+1 required 0", rf_we); end
    cyc();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      errors++; $display("FAIL mul_latency: got we=%b rd=%0d at t+2 required we=1 rd=7", rf_we, rf_waddr);
    end
    drain("mul_idle");
  endtask

`ifndef WB_AGE_EN
  task automatic test_full_fifo();
    bit accepted = 0;
    WBmuxSel = 2'b01;
    for (int k = 0; k < 6; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'(1 + k); ALUres = 32'h100 + k;
      exp_q.push_back('{rd: 5'(1 + k), data: 32'h100 + k});
      mul_valid = 1'b1; mul_rd = 5'(20 + (k > 2 ? 2 : k)); mul_data = 32'hA0 + (k > 2 ? 2 : k);
      #1;
      checks += 2;
      if (mul_ready !== (k < 2)) begin
        errors++; $display("FAIL full_ready%0d: got %b required %b", k, mul_ready, k < 2);
      end
      if (pipe_stall !== 1'b0) begin errors++; $display("FAIL full_stall%0d: got %b required 0", k, pipe_stall); end
      cyc();
    end
    pipe_valid = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back('{rd: 5'(20 + k), data: 32'hA0 + k});
    for (int w = 0; w < 4 && !accepted; w++) begin
      #1;
      if (mul_ready === 1'b1) accepted = 1;
      cyc();
    end
    mul_valid = 1'b0;
    checks++;
    if (!accepted) begin errors++; $display("FAIL full_third_push: got never ready, required ready after drop"); end
    drain("full");
  endtask
`else
  task automatic test_aging();
    WBmuxSel = 2'b01;
    pipe_valid = 1'b1; pipe_rd = 5'd1; ALUres = 32'h200;
    exp_q.push_back('{rd: 5'd1, data: 32'h200});
    mul_valid = 1'b1; mul_rd = 5'd3; mul_data = 32'h333;
    cyc();
    mul_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      pipe_rd = 5'(1 + j); ALUres = 32'h200 + j;
      #1;
      checks++;
      if (pipe_stall !== (j == 5)) begin
        errors++; $display("FAIL age_stall%0d: got %b required %b", j, pipe_stall, j == 5);
      end
      if (j < 5) exp_q.push_back('{rd: 5'(1 + j), data: 32'h200 + j});
      else       exp_q.push_back('{rd: 5'd3, data: 32'h333});
      cyc();
    end
    #1;
    checks++;
    if (pipe_stall !== 1'b0) begin errors++; $display("FAIL age_unstall: got %b required 0", pipe_stall); end
    exp_q.push_back('{rd: 5'd6, data: 32'h205});
    cyc();
    pipe_valid = 1'b0;
    drain("aging");
  endtask
`endif

  task automatic test_x0();
    pipe_valid = 1'b1; pipe_rd = 5'd0; WBmuxSel = 2'b11; IMMin = 32'h5;
    cyc();
    pipe_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_pipe_we: got %b required 0", rf_we); end
    mul_valid = 1'b1; mul_rd = 5'd0; mul_data = 32'h77;
    cyc();
    mul_valid = 1'b0;
    cyc();
    checks++;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_mul_we: got %b required 0", rf_we); end
    // Two pushes under a busy pipe fill the FIFO only if the x0 entry left.
    WBmuxSel = 2'b01;
    pipe_valid = 1'b1; pipe_rd = 5'd14; ALUres = 32'h140;
    mul_valid = 1'b1; mul_rd = 5'd12; mul_data = 32'hC12;
    exp_q.push_back('{rd: 5'd14, data: 32'h140});
    #1;
    checks++;
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL x0_ready_a: got %b required 1", mul_ready); end
    cyc();
    pipe_rd = 5'd15; ALUres = 32'h150; mul_rd = 5'd13; mul_data = 32'hC13;
    exp_q.push_back('{rd: 5'd15, data: 32'h150});
    #1;
    checks++;
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL x0_popped: got ready=%b required 1", mul_ready); end
    cyc();
    pipe_valid = 1'b0; mul_valid = 1'b0;
    #1;
    checks++;
    if (mul_ready !== 1'b0) begin errors++; $display("FAIL x0_full: got ready=%b required 0", mul_ready); end
    exp_q.push_back('{rd: 5'd12, data: 32'hC12});
    exp_q.push_back('{rd: 5'd13, data: 32'hC13});
    drain("x0");
  endtask

  task automatic test_reset_mid();
    WBmuxSel = 2'b01;
    for (int k = 0; k < 3; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'(16 + k); ALUres = 32'h300 + k;
      exp_q.push_back('{rd: 5'(16 + k), data: 32'h300 + k});
      mul_valid = (k < 2); mul_rd = 5'(20 + k); mul_data = 32'hBAD0 + k;
      if (k == 2) begin
        #1;
        checks++;
        if (mul_ready !== 1'b0) begin errors++; $display("FAIL mid_full: got ready=%b required 0", mul_ready); end
      end
      cyc();
    end
    rst_n = 1'b0; pipe_valid = 1'b0; mul_valid = 1'b0;
    cyc();
    checks += 3;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_we: got %b required 0", rf_we); end
    if (rf_waddr !== 5'd0) begin errors++; $display("FAIL mid_waddr: got %0d required 0", rf_waddr); end
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b required 1", mul_ready); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (mul_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_release: got %b required 1", mul_ready); end
    drain("reset_mid");
  endtask

  initial begin
    rst_n = 1'b0; pipe_valid = 1'b0; pipe_rd = '0; WBmuxSel = '0;
    ALUres = '0; MEMread = '0; NPCin = '0; IMMin = '0;
    mul_valid = 1'b0; mul_rd = '0; mul_data = '0;
    test_reset();
    test_pipe();
    test_mul_idle();
`ifndef WB_AGE_EN
    test_full_fifo();
`else
    test_aging();
`endif
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data width.
REQ-002 SHALL have parameter AGE_MAX, default 4, starvation limit in cycles (used only with WB_AGE_EN).
REQ-003 SHALL have ports: clk  in  1  clock; one clock; reset is synchronous and active-low, port rst_n  in  1.
REQ-004 SHALL have ports: pipe_valid  in  1  WB-stage instruction valid; pipe_rd  in  5  destination; WBmuxSel  in  2  from CU.
REQ-005 SHALL have ports: ALUres, MEMread, NPCin, IMMin  in  N each  WB candidates.
REQ-006 SHALL have ports: mul_valid  in  1; mul_ready  out  1; mul_rd  in  5; mul_data  in  N  long-latency unit result.
REQ-007 SHALL have ports: rf_we  out  1; rf_waddr  out  5; rf_wdata  out  N  register-file write port; pipe_stall  out  1.

Function
REQ-008 SHALL select pipeline data: WBmuxSel 00 NPCin, 01 ALUres, 10 MEMread, 11 IMMin.
REQ-009 SHALL hold a 2-entry FIFO of {rd, data} for long-latency results; mul_ready = not full.
REQ-010 SHALL push on mul_valid && mul_ready; no push when full, even if a pop occurs the same cycle.
REQ-011 SHALL not bypass: a result pushed into an empty FIFO is eligible for the write port the next cycle at the earliest.
REQ-012 SHALL arbitrate each cycle: override active -> FIFO head; else pipe_valid -> pipeline; else FIFO non-empty -> FIFO head; else idle.
REQ-013 SHALL pop the FIFO head exactly in the cycle it wins arbitration.
REQ-014 SHALL register the winner: rf_we/rf_waddr/rf_wdata valid one cycle after arbitration; idle cycle -> rf_we=0, rf_waddr/rf_wdata hold.
REQ-015 SHALL suppress writes to x0: winner with rd==0 consumes its slot (pops if FIFO) but drives rf_we=0.
REQ-016 SHALL not reorder FIFO entries; ordering between pipeline and FIFO writes to the same rd is the issuer's responsibility.
REQ-017 SHALL drive pipe_stall combinationally = override active && pipe_valid; a stalled pipeline entry is not written that cycle.
REQ-018 SHALL wrap FIFO read/write pointers modulo 2 with a separate count (0..2).

Reset
REQ-019 SHALL, on rising clk with rst_n=0: FIFO count/pointers 0, age counter 0, rf_we 0, rf_waddr 0, rf_wdata 0.
REQ-020 SHALL discard FIFO contents and any pending arbitration on reset mid-operation; mul_ready=1 the first cycle after reset release.

Configuration
REQ-021 SHALL compile starvation aging only when WB_AGE_EN is defined.
REQ-022 With WB_AGE_EN: age counter increments each cycle FIFO non-empty and no pop, saturates at AGE_MAX, clears on pop or when FIFO empty; override active when age==AGE_MAX.
REQ-023 Without WB_AGE_EN: no age counter, override never active, pipe_stall tied 0; FIFO drains only in pipeline bubbles.

Structure
REQ-024 SHALL place WBmuxSel encoding enum (WB_NPC, WB_ALU, WB_MEM, WB_IMM) and FIFO depth constant in shared package wb_pkg.
REQ-025 SHALL implement the 4:1 select as sub-module wb_sel_mux; FIFO and arbitration stay in wb_arbiter.

Verification
REQ-026 Pipe only: pipe_valid=1, rd=5, WBmuxSel=01, ALUres=0x11 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x11.
REQ-027 Mul into idle pipe: mul_valid=1, rd=7, data=0xABCD at cycle t -> rf_we=1, waddr=7, wdata=0xABCD at t+2.
REQ-028 Full FIFO: three mul results back-to-back, pipe_valid=1 continuously, macro undefined -> mul_ready=0 after 2 pushes, third held; no mul writes until pipe_valid drops.
REQ-029 Aging (WB_AGE_EN, AGE_MAX=4): FIFO holding rd=3, pipe_valid=1 continuously -> pipe_stall=1 on 5th cycle, rd=3 written next cycle, pipe_stall=0 after.
REQ-030 x0: pipe rd=0, WBmuxSel=11, IMMin=0x5 -> rf_we=0; FIFO rd=0 entry popped with rf_we=0.
REQ-031 Reset mid-op: FIFO count 2, rst_n=0 one cycle -> rf_we=0, mul_ready=1, no stale write afterward.
